mem_stage_unit: RTL
===================

Name: mem_stage_unit

Overview:
MEM-stage consumer of the EX/MEM pipeline register outputs (mwreg, mm2reg, mwmem, mrd, mr, mqb) in the single-issue 5-stage CPU.
- Performs the load/store against an external data memory through a req/ack handshake.
- Stalls upstream while the access is pending.
- Drives the MEM/WB register toward write-back.
- Non-memory instructions pass through with one-cycle latency.

Parameters:
DW, 32, data/address width
RW, 5, register-index width
WAIT_MAX, 255, max WAIT cycles before watchdog abort (counter width 8 bits, derived from WAIT_MAX)

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
mwreg  in  1  instruction writes a register
mm2reg  in  1  load (result from memory)
mwmem  in  1  store
mrd  in  RW  destination register
mr  in  DW  ALU result / memory address
mqb  in  DW  store data
stall  out  1  freeze PC/IF/ID/EX and EX/MEM register (combinational)
dmem_req  out  1  memory request (registered)
dmem_we  out  1  write enable, valid with dmem_req
dmem_addr  out  DW  word address, valid with dmem_req
dmem_wdata  out  DW  store data
dmem_ack  in  1  memory done; one-cycle pulse
dmem_rdata  in  DW  load data, valid with dmem_ack
wwreg  out  1  MEM/WB write-enable
wm2reg  out  1  MEM/WB select memory data
wrd  out  RW  MEM/WB destination
walu  out  DW  MEM/WB ALU result
wmo  out  DW  MEM/WB memory data
mem_err  out  1  sticky watchdog-timeout flag

Behaviour:
- Reset: all outputs 0; state IDLE; wait counter 0; mem_err cleared.
  - Reset mid-access drops dmem_req on the same edge.
  - A later dmem_ack is ignored.
- access = mm2reg | mwmem. If mm2reg and mwmem are both 1, the instruction is treated as a load (mwmem ignored).
- stall = (IDLE & access) | WAIT.
- FSM:
  - IDLE
    - access=0: MEM/WB loads mwreg, mm2reg, mrd, mr; wmo=0. Latency 1 cycle.
    - access=1: register dmem_req=1, dmem_we=mwmem&~mm2reg, dmem_addr={mr[DW-1:2],2'b00}, dmem_wdata=mqb; load a MEM/WB bubble (wwreg=0, wm2reg=0); go to WAIT.
  - WAIT
    - MEM/WB loads a bubble each cycle; counter increments.
    - dmem_ack=1: capture dmem_rdata into the data latch, drop dmem_req, clear counter, go to DONE.
    - Counter reaches WAIT_MAX without ack: drop dmem_req, set mem_err, data latch = 32'hDEADBEEF, go to DONE.
  - DONE
    - stall=0; MEM/WB loads mwreg, mm2reg, mrd, mr, and wmo = data latch (0 for stores); go to IDLE.
    - The EX/MEM register advances on the same edge.
- Occupancy: ack in the first WAIT cycle gives 3 cycles (IDLE, WAIT, DONE); each extra ack delay adds 1 cycle.
- Back-to-back memory ops: after DONE the next instruction is seen in IDLE; no request is issued in DONE.
- dmem_ack outside WAIT is ignored. dmem_req is held stable until ack or abort.

Optional Feature:
MISALIGN_TRAP_EN
- Defined: adds output misalign (1 bit, registered, reset 0).
  - An access with mr[1:0]!=0 issues no request; IDLE goes directly to DONE.
  - In DONE, wwreg is forced to 0 and misalign pulses 1 for one cycle.
- Undefined: low address bits are silently truncated and the access proceeds normally.

Decomposition:
- Package mem_stage_pkg: state enum (IDLE, WAIT, DONE); DW/RW defaults; TIMEOUT_DATA = 32'hDEADBEEF.
- Sub-module mem_wb_reg: MEM/WB register with bubble-load input and synchronous reset. The FSM and handshake stay in mem_stage_unit.

Test Plan:
- ALU op: mwreg=1, mrd=5, mr=0x1234, no access -> next edge wwreg=1, wrd=5, walu=0x1234, stall never 1.
- Load, ack 2 cycles after req: mm2reg=1, mr=0x100, rdata=0xCAFE0001 -> dmem_addr=0x100, dmem_we=0, stall high 3 cycles, then wm2reg=1, wmo=0xCAFE0001.
- Store, immediate ack: mwmem=1, mr=0x20, mqb=0x55 -> dmem_we=1, dmem_wdata=0x55, stall 2 cycles, wwreg=0.
- Watchdog: load with no ack -> after WAIT_MAX cycles, mem_err=1, wmo=0xDEADBEEF, pipeline resumes.
- Reset asserted in WAIT, followed by a late ack -> dmem_req=0 next edge, state IDLE, all outputs 0, ack ignored.
- (MISALIGN_TRAP_EN) load with mr=0x102 -> no dmem_req, misalign pulse, wwreg=0.

Source files
------------

// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_stage_pkg : state encoding, defaults and abort data for the MEM stage
// Rev 1.0
// ----------------------------------------------------------------------------
package mem_stage_pkg;

  localparam int DW_DEFAULT       = 32;
  localparam int RW_DEFAULT       = 5;
  localparam int WAIT_MAX_DEFAULT = 255;

  localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_WAIT = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  function automatic int cnt_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_wb_reg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_wb_reg : MEM/WB pipeline register; loads every cycle, bubble clears it
// Rev 1.0
// ----------------------------------------------------------------------------
module mem_wb_reg
  import mem_stage_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int RW = RW_DEFAULT
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          bubble_i,
  input  logic          wreg_i,
  input  logic          m2reg_i,
  input  logic [RW-1:0] rd_i,
  input  logic [DW-1:0] alu_i,
  input  logic [DW-1:0] mo_i,
  output logic          wreg_o,
  output logic          m2reg_o,
  output logic [RW-1:0] rd_o,
  output logic [DW-1:0] alu_o,
  output logic [DW-1:0] mo_o
);

  logic          wreg_q;
  logic          m2reg_q;
  logic [RW-1:0] rd_q;
  logic [DW-1:0] alu_q;
  logic [DW-1:0] mo_q;

  always_ff @(posedge clock) begin
    if (reset || bubble_i) begin
      wreg_q  <= 1'b0;
      m2reg_q <= 1'b0;
      rd_q    <= '0;
      alu_q   <= '0;
      mo_q    <= '0;
    end else begin
      wreg_q  <= wreg_i;
      m2reg_q <= m2reg_i;
      rd_q    <= rd_i;
      alu_q   <= alu_i;
      mo_q    <= mo_i;
    end
  end

  assign wreg_o  = wreg_q;
  assign m2reg_o = m2reg_q;
  assign rd_o    = rd_q;
  assign alu_o   = alu_q;
  assign mo_o    = mo_q;

endmodule
`default_nettype wire

// File: rtl/mem_stage_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mem_stage_unit : MEM stage with req/ack data-memory handshake and watchdog
// Optional macro MISALIGN_TRAP_EN adds the misalign trap output.  Rev 1.0
// ----------------------------------------------------------------------------
module mem_stage_unit
  import mem_stage_pkg::*;
#(
  parameter int DW       = DW_DEFAULT,
  parameter int RW       = RW_DEFAULT,
  parameter int WAIT_MAX = WAIT_MAX_DEFAULT
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          mwreg,
  input  logic          mm2reg,
  input  logic          mwmem,
  input  logic [RW-1:0] mrd,
  input  logic [DW-1:0] mr,
  input  logic [DW-1:0] mqb,
  output logic          stall,
  output logic          dmem_req,
  output logic          dmem_we,
  output logic [DW-1:0] dmem_addr,
  output logic [DW-1:0] dmem_wdata,
  input  logic          dmem_ack,
  input  logic [DW-1:0] dmem_rdata,
  output logic          wwreg,
  output logic          wm2reg,
  output logic [RW-1:0] wrd,
  output logic [DW-1:0] walu,
  output logic [DW-1:0] wmo,
`ifdef MISALIGN_TRAP_EN
  output logic          misalign,
`endif
  output logic          mem_err
);

  localparam int            CW        = cnt_width(WAIT_MAX);
  // Abort fires at the end of the WAIT_MAX-th WAIT cycle without an ack.
  localparam logic [CW-1:0] CNT_LAST  = CW'(WAIT_MAX - 1);
  localparam logic [DW-1:0] ADDR_MASK = ~DW'(3);

  state_t        state_q, state_d;
  logic          req_q, req_d;
  logic          we_q, we_d;
  logic [DW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] latch_q, latch_d;
  logic          err_q, err_d;
  logic          trap_q, trap_d;
`ifdef MISALIGN_TRAP_EN
  logic          misalign_q, misalign_d;
`endif

  logic          w_access;
  logic          w_store;
  logic          w_misal;
  logic          w_bubble;
  logic          w_wb_wreg;
  logic [DW-1:0] w_wb_mo;

  assign w_access = mm2reg | mwmem;
  assign w_store  = mwmem & ~mm2reg;
`ifdef MISALIGN_TRAP_EN
  assign w_misal  = w_access & (mr[1:0] != 2'b00);
`else
  assign w_misal  = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    latch_d   = latch_q;
    err_d     = err_q;
    trap_d    = trap_q;
    w_bubble  = 1'b1;
    w_wb_wreg = mwreg;
    w_wb_mo   = '0;
`ifdef MISALIGN_TRAP_EN
    misalign_d = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (!w_access) begin
          w_bubble = 1'b0;
        end else if (w_misal) begin
          trap_d  = 1'b1;
          latch_d = '0;
          state_d = ST_DONE;
        end else begin
          req_d   = 1'b1;
          we_d    = w_store;
          addr_d  = mr & ADDR_MASK;
          wdata_d = mqb;
          latch_d = '0;
          cnt_d   = '0;
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (dmem_ack) begin
          latch_d = dmem_rdata;
          req_d   = 1'b0;
          cnt_d   = '0;
          state_d = ST_DONE;
        end else if (cnt_q == CNT_LAST) begin
          latch_d = DW'(TIMEOUT_DATA);
          req_d   = 1'b0;
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_DONE: begin
        // EX/MEM still holds the completed instruction on this cycle.
        w_bubble = 1'b0;
        w_wb_mo  = mm2reg ? latch_q : '0;
        if (trap_q) begin
          w_wb_wreg = 1'b0;
`ifdef MISALIGN_TRAP_EN
          misalign_d = 1'b1;
`endif
        end
        trap_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      latch_q <= '0;
      err_q   <= 1'b0;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      latch_q <= latch_d;
      err_q   <= err_d;
      trap_q  <= trap_d;
    end
  end

`ifdef MISALIGN_TRAP_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= misalign_d;
    end
  end

  assign misalign = misalign_q;
`endif

  mem_wb_reg #(
    .DW (DW),
    .RW (RW)
  ) u_mem_wb_reg (
    .clock    (clock),
    .reset    (reset),
    .bubble_i (w_bubble),
    .wreg_i   (w_wb_wreg),
    .m2reg_i  (mm2reg),
    .rd_i     (mrd),
    .alu_i    (mr),
    .mo_i     (w_wb_mo),
    .wreg_o   (wwreg),
    .m2reg_o  (wm2reg),
    .rd_o     (wrd),
    .alu_o    (walu),
    .mo_o     (wmo)
  );

  assign stall      = ((state_q == ST_IDLE) & w_access) | (state_q == ST_WAIT);
  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign mem_err    = err_q;

endmodule
`default_nettype wire
